pio_in_edge_irq: RTL and testbench

//  Parametrised Avalon-MM input PIO for push-buttons and switches. Per bit: 2-FF synchroniser,

---
 rtl/pio_in_edge_irq_if.sv | 15 +
 rtl/pio_in_edge_irq.sv | 81 ++++++++
 tb/tb_pio_in_edge_irq.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/pio_in_edge_irq_if.sv
// pio_in_edge_irq_if: Avalon-MM slave bus bundle for pio_in_edge_irq.
//   address[1:0]    word address (master -> slave)
//   chipselect      slave select
//   write_n         write strobe, active-low
//   writedata[31:0] write data
//   readdata[31:0]  registered read data (slave -> master)
interface pio_in_edge_irq_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/pio_in_edge_irq.sv
// pio_in_edge_irq: Avalon-MM input PIO with synchroniser, optional debounce, per-bit edge
// polarity, sticky W1C edge capture and masked level interrupt.
//   clk      clock
//   reset_n  asynchronous active-low reset
//   bus      Avalon-MM slave (address, chipselect, write_n, writedata, readdata)
//   in_port  asynchronous external inputs, WIDTH bits
//   irq      level interrupt, active-high
// Register map: 0 DATA (RO), 1 POLARITY (RW), 2 IRQ_MASK (RW), 3 EDGE_CAPTURE (R, W1C).
// Define PIO_IN_DEBOUNCE_EN to insert a per-bit debounce filter of DEBOUNCE_CYC stable cycles.
module pio_in_edge_irq #(
    parameter int               WIDTH        = 4,
    parameter logic [WIDTH-1:0] IDLE_VALUE   = '0,
    parameter logic [WIDTH-1:0] POL_RESET    = '0,
    parameter int               DEBOUNCE_CYC = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    pio_in_edge_irq_if.slave bus,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);
    logic [WIDTH-1:0] s1, s2, filt, filt_d, pol, mask, cap, edge_hit, clr;
    logic             wr, unused_wd;
    assign wr        = bus.chipselect & ~bus.write_n;
    assign unused_wd = ^bus.writedata;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= IDLE_VALUE;
            s2 <= IDLE_VALUE;
        end else begin
            s1 <= in_port;
            s2 <= s1;
        end
    end
`ifdef PIO_IN_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    for (genvar i = 0; i < WIDTH; i++) begin : g_deb
        logic          f;
        logic [CW-1:0] c;
        // Count consecutive cycles where the synchronised input disagrees with the filter.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                f <= IDLE_VALUE[i];
                c <= '0;
            end else if (s2[i] == f) begin
                c <= '0;
            end else if (c == CW'(DEBOUNCE_CYC - 1)) begin
                f <= s2[i];
                c <= '0;
            end else begin
                c <= c + 1'b1;
            end
        end
        assign filt[i] = f;
    end
`else
    assign filt = s2;
`endif
    // Polarity applies directly to the current filt/filt_d comparison.
    assign edge_hit = (pol & filt & ~filt_d) | (~pol & ~filt & filt_d);
    assign clr      = (wr && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_d       <= IDLE_VALUE;
            pol          <= POL_RESET;
            mask         <= '0;
            cap          <= '0;
            bus.readdata <= '0;
        end else begin
            filt_d <= filt;
            if (wr && bus.address == 2'd1) pol <= bus.writedata[WIDTH-1:0];
            if (wr && bus.address == 2'd2) mask <= bus.writedata[WIDTH-1:0];
            // A new edge in the same cycle as its clear keeps the bit set.
            cap <= (cap & ~clr) | edge_hit;
            bus.readdata <= bus.address == 2'd0 ? 32'(filt) :
                            bus.address == 2'd1 ? 32'(pol)  :
                            bus.address == 2'd2 ? 32'(mask) : 32'(cap);
        end
    end
    assign irq = |(cap & mask);
endmodule

// File: tb/tb_pio_in_edge_irq.sv
// tb_pio_in_edge_irq: directed self-checking bench for pio_in_edge_irq (WIDTH=4, IDLE=F, POL=0).
module tb_pio_in_edge_irq;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] in_port = 4'hF;
    logic       irq;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [31:0] rd;

    pio_in_edge_irq_if bus();

    pio_in_edge_irq #(.WIDTH(4), .IDLE_VALUE(4'hF), .POL_RESET(4'h0), .DEBOUNCE_CYC(16)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .in_port(in_port), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic bus_idle();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 2'd0;
        bus.writedata  = '0;
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.address = a;
        @(negedge clk);
        d = bus.readdata;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (bus.readdata !== 32'h0) begin n_bad++; $display("FAIL reset_readdata got=%h exp=%h", bus.readdata, 32'h0); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
        @(negedge clk); reset_n = 1'b1;
        wait_cyc(4);
        read_reg(0, rd);
        n_cmp++; if (rd !== 32'hF) begin n_bad++; $display("FAIL reset_data got=%h exp=%h", rd, 32'hF); end
        read_reg(3, rd);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL reset_cap got=%h exp=%h", rd, 32'h0); end
    endtask

    task automatic test_capture();
        write_reg(2, 32'h4);
        @(negedge clk); in_port = 4'hB;
        wait_cyc(2);
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL cap_latency_early got=%b exp=0", irq); end
        wait_cyc(1);
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL cap_latency_irq got=%b exp=1", irq); end
        read_reg(3, rd);
        n_cmp++; if (rd !== 32'h4) begin n_bad++; $display("FAIL cap_value got=%h exp=%h", rd, 32'h4); end
        read_reg(0, rd);
        n_cmp++; if (rd !== 32'hB) begin n_bad++; $display("FAIL cap_data got=%h exp=%h", rd, 32'hB); end
    endtask

    task automatic test_w1c();
        write_reg(3, 32'h4);
        read_reg(3, rd);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL w1c_clear got=%h exp=%h", rd, 32'h0); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL w1c_irq_low got=%b exp=0", irq); end
        @(negedge clk); in_port = 4'hF;
        wait_cyc(4);
        @(negedge clk); in_port = 4'hA;
        wait_cyc(4);
        read_reg(3, rd);
        n_cmp++; if (rd !== 32'h5) begin n_bad++; $display("FAIL w1c_two_edges got=%h exp=%h", rd, 32'h5); end
        write_reg(3, 32'h1);
        write_reg(3, 32'h0);
        write_reg(0, 32'h0);
        read_reg(3, rd);
        n_cmp++; if (rd !== 32'h4) begin n_bad++; $display("FAIL w1c_per_bit got=%h exp=%h", rd, 32'h4); end
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL w1c_irq_high got=%b exp=1", irq); end
        read_reg(0, rd);
        n_cmp++; if (rd !== 32'hA) begin n_bad++; $display("FAIL w1c_data_ro got=%h exp=%h", rd, 32'hA); end
    endtask

    task automatic test_edge_wins();
        write_reg(3, 32'hF);
        @(negedge clk); in_port = 4'h8;
        @(negedge clk);
        write_reg(3, 32'h2);
        read_reg(3, rd);
        n_cmp++; if (rd !== 32'h2) begin n_bad++; $display("FAIL edge_wins got=%h exp=%h", rd, 32'h2); end
    endtask

    task automatic test_polarity();
        write_reg(1, 32'hF);
        write_reg(3, 32'hF);
        read_reg(1, rd);
        n_cmp++; if (rd !== 32'hF) begin n_bad++; $display("FAIL pol_readback got=%h exp=%h", rd, 32'hF); end
        read_reg(3, rd);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL pol_change_no_edge got=%h exp=%h", rd, 32'h0); end
        @(negedge clk); in_port = 4'h9;
        wait_cyc(4);
        read_reg(3, rd);
        n_cmp++; if (rd !== 32'h1) begin n_bad++; $display("FAIL pol_rise got=%h exp=%h", rd, 32'h1); end
        read_reg(0, rd);
        n_cmp++; if (rd !== 32'h9) begin n_bad++; $display("FAIL pol_data got=%h exp=%h", rd, 32'h9); end
        write_reg(3, 32'hF);
        @(negedge clk); in_port = 4'h8;
        wait_cyc(4);
        read_reg(3, rd);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL pol_fall_ignored got=%h exp=%h", rd, 32'h0); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); in_port = 4'hF;
        wait_cyc(4);
        write_reg(1, 32'h0);
        @(negedge clk); in_port = 4'h7;
        wait_cyc(4);
        read_reg(3, rd);
        n_cmp++; if (rd !== 32'hF) begin n_bad++; $display("FAIL rst_setup_cap got=%h exp=%h", rd, 32'hF); end
        write_reg(2, 32'hF);
        @(negedge clk); in_port = 4'hF;
        wait_cyc(4);
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL rst_setup_irq got=%b exp=1", irq); end
        bus.address = 2'd3;
        wait_cyc(1);
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL rst_async_irq got=%b exp=0", irq); end
        n_cmp++; if (bus.readdata !== 32'h0) begin n_bad++; $display("FAIL rst_async_readdata got=%h exp=%h", bus.readdata, 32'h0); end
        wait_cyc(2);
        reset_n = 1'b1;
        wait_cyc(5);
        read_reg(3, rd);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL rst_release_cap got=%h exp=%h", rd, 32'h0); end
        read_reg(2, rd);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL rst_mask got=%h exp=%h", rd, 32'h0); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL rst_release_irq got=%b exp=0", irq); end
    endtask

`ifdef PIO_IN_DEBOUNCE_EN
    task automatic test_debounce();
        write_reg(3, 32'hF);
        @(negedge clk); in_port = 4'hE;
        wait_cyc(10);
        in_port = 4'hF;
        wait_cyc(30);
        read_reg(3, rd);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL deb_glitch_cap got=%h exp=%h", rd, 32'h0); end
        @(negedge clk); in_port = 4'hE;
        wait_cyc(20);
        read_reg(3, rd);
        n_cmp++; if (rd !== 32'h1) begin n_bad++; $display("FAIL deb_long_cap got=%h exp=%h", rd, 32'h1); end
        read_reg(0, rd);
        n_cmp++; if (rd !== 32'hE) begin n_bad++; $display("FAIL deb_data got=%h exp=%h", rd, 32'hE); end
        @(negedge clk); in_port = 4'hF;
        wait_cyc(24);
    endtask
`endif

    initial begin
        bus_idle();
        test_reset();
        test_capture();
        test_w1c();
        test_edge_wins();
        test_polarity();
`ifdef PIO_IN_DEBOUNCE_EN
        test_debounce();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
